// File: rtl/vga_sync_800x600_if.sv
// Purpose: pixel timing bundle from the sync generator to the graphics block and VGA pins.
// Latency: signals only; every member is driven straight from a register in the generator.
// Backpressure: none; the timing stream free-runs and consumers sample it on p_tick.
interface vga_sync_800x600_if;
    logic        p_tick;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        video_on;
    logic        hsync;
    logic        vsync;
    logic        frame_tick;
    logic [15:0] frame_cnt;

    modport master (
        output p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_tick, frame_cnt
    );

    modport slave (
        input  p_tick, pix_x, pix_y, video_on, hsync, vsync, frame_tick, frame_cnt
    );
endinterface

// File: rtl/vga_sync_800x600.sv
// Purpose: SVGA 800x600@72 pixel-enable, x/y counters, syncs and video_on (frame_cnt optional
//          via VGA_SYNC_FRAME_CNT_EN; when undefined frame_cnt is tied to zero).
// Latency: all outputs registered from next-counter values, so they align to the same pixel.
// Backpressure: none; free-running, cannot be stalled.
module vga_sync_800x600 #(
    parameter int CLK_DIV = 2,
    parameter int H_DISP  = 800,
    parameter int H_FP    = 56,
    parameter int H_SYNC  = 120,
    parameter int H_BP    = 64,
    parameter int V_DISP  = 600,
    parameter int V_FP    = 37,
    parameter int V_SYNC  = 6,
    parameter int V_BP    = 23,
    parameter int HS_POL  = 1,
    parameter int VS_POL  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    vga_sync_800x600_if.master   vga
);

    localparam int          H_TOT    = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int          V_TOT    = V_DISP + V_FP + V_SYNC + V_BP;
    localparam logic [4:0]  DIV_LAST = 5'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOT - 1);
    localparam logic [10:0] H_VIS    = 11'(H_DISP);
    localparam logic [10:0] V_VIS    = 11'(V_DISP);
    localparam logic [10:0] HS_START = 11'(H_DISP + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_DISP + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_DISP + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_DISP + V_FP + V_SYNC);
    localparam logic        HS_ON    = 1'(HS_POL);
    localparam logic        VS_ON    = 1'(VS_POL);

    logic [4:0]  div_cnt;
    logic [4:0]  div_nxt;
    logic        tick_nxt;
    logic        p_tick_r;
    logic [10:0] x_r;
    logic [10:0] y_r;
    logic [10:0] x_nxt;
    logic [10:0] y_nxt;
    logic        video_on_r;
    logic        hsync_r;
    logic        vsync_r;
    logic        frame_tick_r;

    // Next-state of the divider and the counters; counters step only in a p_tick cycle.
    // Comparisons use >= so a corrupted counter falls back to 0 on its next step.
    always_comb begin
        div_nxt  = (div_cnt >= DIV_LAST) ? 5'd0 : div_cnt + 5'd1;
        tick_nxt = (div_nxt == DIV_LAST);
        x_nxt    = x_r;
        y_nxt    = y_r;
        if (p_tick_r) begin
            if (x_r >= H_LAST) begin
                x_nxt = 11'd0;
                y_nxt = (y_r >= V_LAST) ? 11'd0 : y_r + 11'd1;
            end else begin
                x_nxt = x_r + 11'd1;
            end
        end
    end

    // Timing state; decoded outputs come from the next-counter values so they match pix_x/pix_y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt      <= 5'd0;
            p_tick_r     <= 1'b0;
            x_r          <= 11'd0;
            y_r          <= 11'd0;
            video_on_r   <= 1'b0;
            hsync_r      <= ~HS_ON;
            vsync_r      <= ~VS_ON;
            frame_tick_r <= 1'b0;
        end else begin
            div_cnt      <= div_nxt;
            p_tick_r     <= tick_nxt;
            x_r          <= x_nxt;
            y_r          <= y_nxt;
            video_on_r   <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
            hsync_r      <= ((x_nxt >= HS_START) && (x_nxt < HS_END)) ? HS_ON : ~HS_ON;
            vsync_r      <= ((y_nxt >= VS_START) && (y_nxt < VS_END)) ? VS_ON : ~VS_ON;
            frame_tick_r <= tick_nxt && (x_nxt == H_LAST) && (y_nxt == V_LAST);
        end
    end

    assign vga.p_tick     = p_tick_r;
    assign vga.pix_x      = x_r;
    assign vga.pix_y      = y_r;
    assign vga.video_on   = video_on_r;
    assign vga.hsync      = hsync_r;
    assign vga.vsync      = vsync_r;
    assign vga.frame_tick = frame_tick_r;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Frame counter steps on the same edge that wraps pix_y back to 0; rolls over naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_r <= 16'd0;
        end else if (frame_tick_r) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end
    end

    assign vga.frame_cnt = frame_cnt_r;
`else
    assign vga.frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_sync_800x600.sv
// Purpose: scoreboard bench for vga_sync_800x600 on a shrunken raster, model from raster arithmetic.
// Latency: expected outputs derived from clk edges since reset release, checked each negedge.
// Backpressure: none; reset is dropped in mid-frame and at random to check async recovery.
module tb_vga_sync_800x600;

    localparam int D     = 2;
    localparam int HD    = 16;
    localparam int HF    = 3;
    localparam int HSW   = 4;
    localparam int HB    = 5;
    localparam int VD    = 10;
    localparam int VF    = 2;
    localparam int VSW   = 3;
    localparam int VB    = 2;
    localparam int HPOL  = 1;
    localparam int VPOL  = 0;
    localparam int HT    = HD + HF + HSW + HB;
    localparam int VT    = VD + VF + VSW + VB;
    localparam int FRAME = HT * VT;
    localparam int NCYC  = 9000;

    typedef struct packed {
        logic        tick;
        logic [10:0] x;
        logic [10:0] y;
        logic        vo;
        logic        hs;
        logic        vs;
        logic        ft;
        logic [15:0] fc;
    } obs_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    obs_t exp_q[$];

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] fc_base;
`endif

    vga_sync_800x600_if vif ();

    vga_sync_800x600 #(
        .CLK_DIV(D), .H_DISP(HD), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_DISP(VD), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(HPOL), .VS_POL(VPOL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vga   (vif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: k = clk edges seen since reset release; pixel index is k/D, raster is row-major.
    function automatic obs_t model(input int k);
        obs_t o;
        int   p;
        int   x;
        int   y;
        o.tick = 1'b0;
        o.x    = 11'd0;
        o.y    = 11'd0;
        o.vo   = 1'b0;
        o.hs   = ~1'(HPOL);
        o.vs   = ~1'(VPOL);
        o.ft   = 1'b0;
        o.fc   = 16'd0;
        if (k > 0) begin
            p      = k / D;
            x      = p % HT;
            y      = (p / HT) % VT;
            o.tick = ((k % D) == D - 1);
            o.x    = 11'(x);
            o.y    = 11'(y);
            o.vo   = (x < HD) && (y < VD);
            o.hs   = (x >= HD + HF && x < HD + HF + HSW) ? 1'(HPOL) : ~1'(HPOL);
            o.vs   = (y >= VD + VF && y < VD + VF + VSW) ? 1'(VPOL) : ~1'(VPOL);
            o.ft   = o.tick && (x == HT - 1) && (y == VT - 1);
`ifdef VGA_SYNC_FRAME_CNT_EN
            o.fc   = fc_base + 16'(p / FRAME);
`endif
        end
        return o;
    endfunction

    // Monitor: every negedge the DUT presents a full timing sample; pop and compare.
    initial begin
        obs_t got;
        obs_t want;
        forever begin
            @(negedge clk);
            got.tick = vif.p_tick;
            got.x    = vif.pix_x;
            got.y    = vif.pix_y;
            got.vo   = vif.video_on;
            got.hs   = vif.hsync;
            got.vs   = vif.vsync;
            got.ft   = vif.frame_tick;
            got.fc   = vif.frame_cnt;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow t=%0t: got a sample, scoreboard empty", $time);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL timing t=%0t: got tick=%0b x=%0d y=%0d vo=%0b hs=%0b vs=%0b ft=%0b fc=%0h, want tick=%0b x=%0d y=%0d vo=%0b hs=%0b vs=%0b ft=%0b fc=%0h",
                             $time, got.tick, got.x, got.y, got.vo, got.hs, got.vs, got.ft, got.fc,
                             want.tick, want.x, want.y, want.vo, want.hs, want.vs, want.ft, want.fc);
                end
            end
        end
    end

    // Stimulus: reset sequencing plus expected-sample generation, one push per clk.
    initial begin
        int k;
        int rst_hold;
        n_cmp    = 0;
        n_bad    = 0;
        k        = 0;
        rst_hold = 3;
        reset    = 1'b1;
`ifdef VGA_SYNC_FRAME_CNT_EN
        fc_base  = 16'd0;
`endif
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            if (!reset) k++;
            if (reset) begin
                rst_hold--;
                if (rst_hold <= 0) reset = 1'b0;
            end else if (c == 3500 || (c > 7000 && $urandom_range(0, 399) == 0)) begin
                reset    = 1'b1;
                rst_hold = (c == 3500) ? 3 : int'($urandom_range(1, 3));
                k        = 0;
`ifdef VGA_SYNC_FRAME_CNT_EN
                fc_base  = 16'd0;
`endif
            end
`ifdef VGA_SYNC_FRAME_CNT_EN
            if (c == 4000) begin
                force dut.frame_cnt_r = 16'hFFFE;
                #1;
                release dut.frame_cnt_r;
                fc_base = 16'hFFFE - 16'((k / D) / FRAME);
            end
`endif
            exp_q.push_back(model(k));
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d samples left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
